// File: rtl/cmd_ram_pkg.sv
// Shared command encoding and address helpers for the command-decoded RAM.
package cmd_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  localparam int ADDR_MAX_W = 32;

  // Increment wrapping at 2**addr_w; callers truncate back to their own width.
  function automatic logic [ADDR_MAX_W-1:0] addr_next(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int unsigned addr_w);
    logic [ADDR_MAX_W-1:0] mask;
    if (addr_w >= ADDR_MAX_W) mask = '1;
    else mask = (ADDR_MAX_W'(1) << addr_w) - ADDR_MAX_W'(1);
    return (addr + ADDR_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/cmd_ram_mem.sv
// Storage array: synchronous write, registered read, no reset.
module cmd_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cmd_ram.sv
// Command-decoded single-port RAM: opcode decode, address registers, error
// detection, read pipeline and tx_valid/tx_ready output handshake.
module cmd_ram
  import cmd_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              cmd_err
);

  cmd_e              op;
  logic [DATA_W-1:0] payload;
  logic              addr_bad;

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_addr_set, rd_addr_set;

  logic              wr_addr_ok, wr_data_ok, rd_addr_ok, rd_data_ok, cmd_bad;
  logic              v1, v2, shift, complete, rd_room;
  logic [DATA_W-1:0] rdata, s2, pipe_data;

  assign op       = cmd_e'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];
  assign addr_bad = (payload >> ADDR_W) != '0;

  // A finished read stalls in the pipeline while the presented word is unaccepted.
  assign complete  = ((READ_LAT == 2) ? v2 : v1) & ~(tx_valid & ~tx_ready);
  assign shift     = v1 & (~v2 | complete);
  assign pipe_data = (READ_LAT == 2) ? s2 : rdata;

  // With one stage, a read retiring on this edge frees its slot for streaming.
  assign rd_room = (READ_LAT == 2) ? (~v1 & ~v2) : (~v1 | complete);

  always_comb begin
    wr_addr_ok = rx_valid & (op == CMD_WR_ADDR) & ~addr_bad;
    wr_data_ok = rx_valid & (op == CMD_WR_DATA) & wr_addr_set;
    rd_addr_ok = rx_valid & (op == CMD_RD_ADDR) & ~addr_bad;
    rd_data_ok = rx_valid & (op == CMD_RD_DATA) & rd_addr_set & rd_room &
                 (~tx_valid | tx_ready);
    cmd_bad    = rx_valid & ~(wr_addr_ok | wr_data_ok | rd_addr_ok | rd_data_ok);
  end

  cmd_ram_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_data_ok),
    .waddr(wr_addr),
    .wdata(payload),
    .re   (rd_data_ok),
    .raddr(rd_addr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_addr_set <= 1'b0;
      rd_addr_set <= 1'b0;
      cmd_err     <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      s2          <= '0;
      dout        <= '0;
      tx_valid    <= 1'b0;
    end else begin
      cmd_err <= cmd_bad;

      if (wr_addr_ok) begin
        wr_addr     <= payload[ADDR_W-1:0];
        wr_addr_set <= 1'b1;
      end else if (wr_data_ok && AUTO_INC != 0) begin
        wr_addr <= ADDR_W'(addr_next(ADDR_MAX_W'(wr_addr), ADDR_W));
      end

      if (rd_addr_ok) begin
        rd_addr     <= payload[ADDR_W-1:0];
        rd_addr_set <= 1'b1;
      end else if (rd_data_ok && AUTO_INC != 0) begin
        rd_addr <= ADDR_W'(addr_next(ADDR_MAX_W'(rd_addr), ADDR_W));
      end

      if (READ_LAT == 2) begin
        if (shift) s2 <= rdata;
        v2 <= shift | (v2 & ~complete);
        v1 <= rd_data_ok | (v1 & ~shift);
      end else begin
        v2 <= 1'b0;
        v1 <= rd_data_ok | (v1 & ~complete);
      end

      if (complete) begin
        dout     <= pipe_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_ram.sv
// Directed bench for cmd_ram: default, ADDR_W=4 and READ_LAT=2/AUTO_INC=0 builds.
module tb_cmd_ram;
  import cmd_ram_pkg::*;

  logic       clk, rst_n, rx_valid, tx_ready;
  logic [9:0] din;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       tv_a, tv_b, tv_c, err_a, err_b, err_c;
  int         checks = 0, failures = 0;
  int         nerr_a = 0, nerr_c = 0, base;

  cmd_ram u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_a), .tx_valid(tv_a), .cmd_err(err_a)
  );

  cmd_ram #(.ADDR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_b), .tx_valid(tv_b), .cmd_err(err_b)
  );

  cmd_ram #(.READ_LAT(2), .AUTO_INC(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_c), .tx_valid(tv_c), .cmd_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_a === 1'b1) nerr_a++;
    if (err_c === 1'b1) nerr_c++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input cmd_e op, input logic [7:0] pl);
    @(negedge clk);
    din      = {op, pl};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    din      = '0;
    do_reset();
    check("reset_tx_valid", 8'(tv_a), 8'h00);
    check("reset_dout", dout_a, 8'h00);
    check("reset_cmd_err", 8'(err_a), 8'h00);

    // basic write burst and streamed reads
    base = nerr_a;
    cmd(CMD_WR_ADDR, 8'h10);
    cmd(CMD_WR_DATA, 8'hAA);
    cmd(CMD_WR_DATA, 8'hBB);
    cmd(CMD_RD_ADDR, 8'h10);
    cmd(CMD_RD_DATA, 8'h00);
    check("basic_lat_not_yet", 8'(tv_a), 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    check("basic_first_valid", 8'(tv_a), 8'h01);
    check("basic_first_data", dout_a, 8'hAA);
    idle();
    check("basic_second_valid", 8'(tv_a), 8'h01);
    check("basic_second_data", dout_a, 8'hBB);
    idle();
    check("basic_drop_valid", 8'(tv_a), 8'h00);
    check("basic_no_err", 8'(nerr_a - base), 8'h00);

    // address wrap 0xFF -> 0x00
    cmd(CMD_WR_ADDR, 8'hFF);
    cmd(CMD_WR_DATA, 8'h11);
    cmd(CMD_WR_DATA, 8'h22);
    cmd(CMD_RD_ADDR, 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    check("wrap_data_00", dout_a, 8'h22);
    cmd(CMD_RD_ADDR, 8'hFF);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    check("wrap_data_ff", dout_a, 8'h11);
    idle();

    // back-pressure
    tx_ready = 1'b0;
    cmd(CMD_WR_ADDR, 8'h40);
    cmd(CMD_WR_DATA, 8'h5A);
    cmd(CMD_WR_DATA, 8'h5B);
    cmd(CMD_RD_ADDR, 8'h40);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    check("bp_valid", 8'(tv_a), 8'h01);
    check("bp_data", dout_a, 8'h5A);
    cmd(CMD_RD_DATA, 8'h00);
    check("bp_refused_err", 8'(err_a), 8'h01);
    check("bp_hold_valid", 8'(tv_a), 8'h01);
    check("bp_hold_data", dout_a, 8'h5A);
    idle();
    check("bp_err_pulse_end", 8'(err_a), 8'h00);
    check("bp_still_held", dout_a, 8'h5A);
    tx_ready = 1'b1;
    idle();
    check("bp_accept_drop", 8'(tv_a), 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    check("bp_refused_no_inc", dout_a, 8'h5B);
    idle();

    // protocol errors straight after reset
    do_reset();
    cmd(CMD_WR_DATA, 8'h33);
    check("perr_wr_data", 8'(err_a), 8'h01);
    cmd(CMD_RD_DATA, 8'h00);
    check("perr_rd_data", 8'(err_a), 8'h01);
    idle();
    check("perr_no_valid", 8'(tv_a), 8'h00);
    check("perr_pulse_end", 8'(err_a), 8'h00);
    cmd(CMD_RD_ADDR, 8'h00);
    check("perr_rd_addr_ok", 8'(err_a), 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    check("perr_mem_unchanged", dout_a, 8'h22);
    idle();

    // ADDR_W=4: out-of-range address rejected
    do_reset();
    cmd(CMD_WR_ADDR, 8'h02);
    cmd(CMD_WR_DATA, 8'h99);
    cmd(CMD_WR_ADDR, 8'h12);
    check("aw4_range_err", 8'(err_b), 8'h01);
    cmd(CMD_WR_DATA, 8'h44);
    check("aw4_wr_ok", 8'(err_b), 8'h00);
    cmd(CMD_RD_ADDR, 8'h02);
    cmd(CMD_RD_DATA, 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    check("aw4_addr2", dout_b, 8'h99);
    idle();
    check("aw4_addr3", dout_b, 8'h44);
    idle();

    // READ_LAT=2, AUTO_INC=0
    do_reset();
    base = nerr_c;
    cmd(CMD_WR_ADDR, 8'h05);
    cmd(CMD_WR_DATA, 8'h66);
    cmd(CMD_RD_ADDR, 8'h05);
    cmd(CMD_RD_DATA, 8'h00);
    check("lat2_edge1", 8'(tv_c), 8'h00);
    cmd(CMD_WR_DATA, 8'h77);
    check("lat2_edge2", 8'(tv_c), 8'h00);
    idle();
    check("lat2_valid", 8'(tv_c), 8'h01);
    check("lat2_old_data", dout_c, 8'h66);
    idle();
    check("lat2_drop", 8'(tv_c), 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    idle();
    idle();
    check("lat2_new_data", dout_c, 8'h77);
    check("lat2_no_err", 8'(nerr_c - base), 8'h00);
    idle();

    // reset while a read is in flight
    cmd(CMD_RD_ADDR, 8'h10);
    cmd(CMD_RD_DATA, 8'h00);
    check("mid_before", 8'(tv_a), 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 8'(tv_a), 8'h00);
    check("mid_rst_dout", dout_a, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_flushed", 8'(tv_a), 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    check("mid_rd_flag_clr", 8'(err_a), 8'h01);
    cmd(CMD_WR_DATA, 8'h00);
    check("mid_wr_flag_clr", 8'(err_a), 8'h01);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_ram.md
Name: cmd_ram

Overview:
Parametrised command-decoded single-port RAM behind the SPI slave's serial-to-parallel front end. Each accepted 2+DATA_W-bit word carries a 2-bit opcode and a payload: set write address, write data, set read address or read data. Over the earlier fixed 256x8 RAM it adds configurable width and depth, optional address auto-increment for bursts, selectable read latency, a tx_ready back-pressure handshake and protocol-error detection.

Parameters:
DATA_W, 8, data and payload width in bits.
ADDR_W, 8, address width; depth = 2**ADDR_W; legal range 1..DATA_W.
READ_LAT, 1, cycles from accepted READ command to tx_valid; legal values 1 or 2.
AUTO_INC, 1, 1 = write/read address increments after each data access; 0 = address held.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  DATA_W+2  [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
rx_valid  input  1  din valid this cycle, one command per asserted cycle
tx_ready  input  1  consumer accepts dout when tx_valid high
dout  output  DATA_W  read data
tx_valid  output  1  dout valid, held until accepted
cmd_err  output  1  one-cycle pulse, command dropped

Behaviour:
- Reset (async, rst_n=0): dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, wr_addr_set=0, rd_addr_set=0, read pipeline flushed. Memory contents not reset.
- Reset mid-read: a pending or presented read is discarded. tx_valid is 0 after release.
- Opcode 00 WR_ADDR: wr_addr <= payload[ADDR_W-1:0], wr_addr_set <= 1.
- Opcode 01 WR_DATA: mem[wr_addr] <= payload. If AUTO_INC, wr_addr <= wr_addr+1, wrapping from 2**ADDR_W-1 to 0.
- Opcode 10 RD_ADDR: rd_addr <= payload[ADDR_W-1:0], rd_addr_set <= 1.
- Opcode 11 RD_DATA: mem[rd_addr] is sampled on the accepting edge. If AUTO_INC, rd_addr increments with the same wrap. dout/tx_valid update READ_LAT edges after the accepting edge. With READ_LAT=2, a WR_DATA to the same address on the following cycle does not affect the returned value.
- The payload is ignored for RD_DATA.
- Handshake: tx_valid stays high and dout stays stable until an edge with tx_ready=1, then tx_valid <= 0 unless a new read completes on that same edge.
- A read is pending from acceptance until tx_valid. At most one read may be in flight or presented.
- RD_DATA is accepted only if no read is pending and (tx_valid=0 or tx_ready=1) in the same cycle. This allows back-to-back streaming at full rate with READ_LAT=1.
- Errors: cmd_err pulses high on the edge after the offending command, and that command has no other effect. Error cases:
  - WR_DATA with wr_addr_set=0
  - RD_DATA with rd_addr_set=0
  - RD_DATA refused by the handshake rule
  - WR_ADDR/RD_ADDR with nonzero payload[DATA_W-1:ADDR_W] (only when ADDR_W<DATA_W)
- rx_valid=0: no state change except the tx handshake and the read pipeline advancing.
- Write addresses and read addresses are independent. Write and read of the same address on successive commands return the new data.

Decomposition:
- Package cmd_ram_pkg:
  - typedef enum logic [1:0] cmd_e {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}
  - function addr_next (wrap increment)
- Sub-module cmd_ram_mem: storage array only. Synchronous write port, registered read port, no reset. The top holds decode, address registers, error logic, read pipeline and tx handshake.

Test Plan:
- Defaults (DATA_W=8, ADDR_W=8, READ_LAT=1, AUTO_INC=1), tx_ready=1.
  - Sequence: 0x0_10, 0x1_AA, 0x1_BB, 0x2_10, 0x3_xx, 0x3_xx.
  - Required: dout=0xAA with tx_valid on the edge after the first READ, then dout=0xBB. cmd_err never asserted.
- Wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 0x00, RD_DATA -> dout=0x22 (address wrapped 0xFF->0x00).
- Back-pressure: tx_ready=0, RD_DATA returns 0x5A, then a second RD_DATA is issued.
  - Required: cmd_err pulse, tx_valid/dout held at 0x5A.
  - Raise tx_ready for one cycle: tx_valid drops.
- Protocol error after reset: WR_DATA 0x33 -> cmd_err pulse, memory unchanged. RD_DATA -> cmd_err pulse, tx_valid stays 0.
- With ADDR_W=4: WR_ADDR 0x12 -> cmd_err, wr_addr unchanged.
- READ_LAT=2, AUTO_INC=0: RD_ADDR 0x05, RD_DATA, then WR_DATA 0x77 to 0x05 on the next cycle.
  - Required: tx_valid two edges after RD_DATA with the old value.
  - Next RD_DATA returns 0x77.
- Assert rst_n mid-read (after RD_DATA, before tx_valid): tx_valid=0, dout=0, address-set flags cleared.
